// File: rtl/ex_mem_latch.sv
// EX/MEM pipeline register: holds execute-stage results for the memory stage
// and owns the dcache request handshake, retiring each request on dhit.
module ex_mem_latch #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              enable,
    input  logic              flush,
    input  logic              dhit,
    input  logic              ex_valid,
    input  logic [WORD_W-1:0] ex_pc,
    input  logic [WORD_W-1:0] ex_aluOut,
    input  logic [WORD_W-1:0] ex_storeData,
    input  logic [REG_W-1:0]  ex_writeReg,
    input  logic              ex_regWEN,
    input  logic              ex_memRead,
    input  logic              ex_memWrite,
    input  logic              ex_memToReg,
    input  logic              ex_halt,
    output logic              mem_valid,
    output logic [WORD_W-1:0] mem_pc,
    output logic [WORD_W-1:0] mem_aluOut,
    output logic [WORD_W-1:0] mem_storeData,
    output logic [REG_W-1:0]  mem_writeReg,
    output logic              mem_regWEN,
    output logic              mem_memToReg,
    output logic              mem_halt,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic              mem_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } reqState_t;

    reqState_t reqState;

    logic newRead;
    logic newWrite;
    logic newRegWEN;

    // Bubbles never issue memory traffic, and a write to r0 is dropped here
    // so the forwarding unit never sees it as a producer.
    assign newRead   = ex_valid & ex_memRead;
    assign newWrite  = ex_valid & ex_memWrite;
    assign newRegWEN = ex_valid & ex_regWEN & (ex_writeReg != '0);

    // NOTE: state registers use non-blocking assignment so every field
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        // Reset and flush leave identical state, so they share one branch.
        if (RST || flush) begin
            mem_valid     <= 1'b0;
            mem_pc        <= '0;
            mem_aluOut    <= '0;
            mem_storeData <= '0;
            mem_writeReg  <= '0;
            mem_regWEN    <= 1'b0;
            mem_memToReg  <= 1'b0;
            mem_halt      <= 1'b0;
            dmemREN       <= 1'b0;
            dmemWEN       <= 1'b0;
            reqState      <= IDLE;
        end else if (enable) begin
            mem_valid     <= ex_valid;
            mem_pc        <= ex_pc;
            mem_aluOut    <= ex_aluOut;
            mem_storeData <= ex_storeData;
            mem_writeReg  <= ex_writeReg;
            mem_regWEN    <= newRegWEN;
            mem_memToReg  <= ex_memToReg & ex_valid;
            mem_halt      <= mem_halt | (ex_halt & ex_valid);
            dmemREN       <= newRead;
            dmemWEN       <= newWrite;
            reqState      <= (newRead || newWrite) ? REQ : IDLE;
        end else if (reqState == REQ && dhit) begin
            // Retire the access so a stalled pipeline never re-issues it.
            dmemREN       <= 1'b0;
            dmemWEN       <= 1'b0;
            reqState      <= IDLE;
        end
    end

    // Combinational so the hazard unit releases the stall in the dhit cycle.
    assign mem_busy  = (reqState == REQ) & ~dhit;
    assign dmemaddr  = mem_aluOut;
    assign dmemstore = mem_storeData;

    // Advancing over an unfinished access loses it; the hazard unit must stall.
    illegalAdvance: assert property (@(posedge CLK) disable iff (RST)
        !(enable && !flush && reqState == REQ && !dhit));

endmodule

// File: tb/tb_ex_mem_latch.sv
// Self-checking bench for ex_mem_latch: directed scenarios followed by
// protocol-respecting random traffic checked against a behavioural model.
module tb_ex_mem_latch;

    logic        CLK = 1'b0;
    logic        RST, enable, flush, dhit;
    logic        ex_valid, ex_regWEN, ex_memRead, ex_memWrite, ex_memToReg, ex_halt;
    logic [31:0] ex_pc, ex_aluOut, ex_storeData;
    logic [4:0]  ex_writeReg;

    logic        mem_valid, mem_regWEN, mem_memToReg, mem_halt;
    logic        dmemREN, dmemWEN, mem_busy;
    logic [31:0] mem_pc, mem_aluOut, mem_storeData, dmemaddr, dmemstore;
    logic [4:0]  mem_writeReg;

    int checks = 0;
    int errors = 0;

    ex_mem_latch #(.WORD_W(32), .REG_W(5)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .flush(flush), .dhit(dhit),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_aluOut(ex_aluOut),
        .ex_storeData(ex_storeData), .ex_writeReg(ex_writeReg),
        .ex_regWEN(ex_regWEN), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
        .ex_memToReg(ex_memToReg), .ex_halt(ex_halt),
        .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_aluOut(mem_aluOut),
        .mem_storeData(mem_storeData), .mem_writeReg(mem_writeReg),
        .mem_regWEN(mem_regWEN), .mem_memToReg(mem_memToReg), .mem_halt(mem_halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .mem_busy(mem_busy)
    );

    always #5 CLK = ~CLK;

    // What the memory stage should be holding, in architectural terms.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] storeData;
        logic [4:0]  writeReg;
        logic        regWEN;
        logic        memToReg;
        logic        halt;
        logic        readPending;
        logic        writePending;
    } expect_t;

    expect_t model;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic expect_t predict(input expect_t cur);
        expect_t nxt;
        nxt = cur;
        if (RST || flush) begin
            nxt = '0;
        end else if (enable) begin
            nxt.valid        = ex_valid;
            nxt.pc           = ex_pc;
            nxt.addr         = ex_aluOut;
            nxt.storeData    = ex_storeData;
            nxt.writeReg     = ex_writeReg;
            nxt.regWEN       = ex_valid && ex_regWEN && (ex_writeReg != 5'd0);
            nxt.memToReg     = ex_valid && ex_memToReg;
            nxt.halt         = cur.halt || (ex_valid && ex_halt);
            nxt.readPending  = ex_valid && ex_memRead;
            nxt.writePending = ex_valid && ex_memWrite;
        end else if (dhit) begin
            // The outstanding access (if any) completes.
            nxt.readPending  = 1'b0;
            nxt.writePending = 1'b0;
        end
        return nxt;
    endfunction

    task automatic compareAll(input string tag);
        check({tag, ".valid"},     mem_valid,     model.valid);
        check({tag, ".pc"},        mem_pc,        model.pc);
        check({tag, ".aluOut"},    mem_aluOut,    model.addr);
        check({tag, ".storeData"}, mem_storeData, model.storeData);
        check({tag, ".writeReg"},  mem_writeReg,  model.writeReg);
        check({tag, ".regWEN"},    mem_regWEN,    model.regWEN);
        check({tag, ".memToReg"},  mem_memToReg,  model.memToReg);
        check({tag, ".halt"},      mem_halt,      model.halt);
        check({tag, ".dmemREN"},   dmemREN,       model.readPending);
        check({tag, ".dmemWEN"},   dmemWEN,       model.writePending);
        check({tag, ".dmemaddr"},  dmemaddr,      model.addr);
        check({tag, ".dmemstore"}, dmemstore,     model.storeData);
    endtask

    // Called at a falling edge with inputs already driven: checks the
    // combinational stall, advances one clock, then checks every output.
    task automatic tick(input string tag);
        #1;
        check({tag, ".busyPre"}, mem_busy,
              (model.readPending || model.writePending) && !dhit);
        @(posedge CLK);
        model = predict(model);
        #1;
        compareAll(tag);
        @(negedge CLK);
    endtask

    task automatic clearInputs();
        RST = 1'b0; enable = 1'b0; flush = 1'b0; dhit = 1'b0;
        ex_valid = 1'b0; ex_regWEN = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0;
        ex_memToReg = 1'b0; ex_halt = 1'b0;
        ex_pc = '0; ex_aluOut = '0; ex_storeData = '0; ex_writeReg = '0;
    endtask

    task automatic randomizeEx();
        ex_valid     = $urandom_range(0, 3) != 0;
        ex_regWEN    = $urandom_range(0, 1) != 0;
        ex_memRead   = $urandom_range(0, 2) == 0;
        ex_memWrite  = $urandom_range(0, 3) == 0;
        ex_memToReg  = $urandom_range(0, 1) != 0;
        ex_halt      = $urandom_range(0, 15) == 0;
        ex_pc        = $urandom;
        ex_aluOut    = $urandom;
        ex_storeData = $urandom;
        ex_writeReg  = 5'($urandom_range(0, 31));
    endtask

    initial begin
        clearInputs();
        model = '0;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);

        // Reset held with noisy inputs.
        for (int i = 0; i < 2; i++) begin
            randomizeEx();
            enable = 1'b1;
            flush  = $urandom_range(0, 1) != 0;
            dhit   = $urandom_range(0, 1) != 0;
            tick("reset");
        end
        check("reset.busy", mem_busy, 1'b0);
        check("reset.dmemREN", dmemREN, 1'b0);

        // Load issue, held three cycles, released by dhit.
        clearInputs();
        enable = 1'b1; ex_valid = 1'b1; ex_memRead = 1'b1;
        ex_aluOut = 32'h0000_0040; ex_writeReg = 5'd5; ex_regWEN = 1'b1;
        tick("loadIssue");
        clearInputs();
        for (int i = 0; i < 3; i++) begin
            randomizeEx();
            tick("loadWait");
            check("loadWait.busy", mem_busy, 1'b1);
            check("loadWait.dmemREN", dmemREN, 1'b1);
            check("loadWait.addr", dmemaddr, 32'h40);
        end
        dhit = 1'b1;
        #1;
        check("loadHit.busy", mem_busy, 1'b0);
        tick("loadHit");
        check("loadDone.dmemREN", dmemREN, 1'b0);
        check("loadDone.writeReg", mem_writeReg, 32'd5);
        check("loadDone.regWEN", mem_regWEN, 1'b1);

        // Store followed back-to-back by a load in the dhit cycle.
        clearInputs();
        enable = 1'b1; ex_valid = 1'b1; ex_memWrite = 1'b1;
        ex_aluOut = 32'h80; ex_storeData = 32'hDEAD_BEEF;
        tick("storeIssue");
        check("storeIssue.store", dmemstore, 32'hDEAD_BEEF);
        enable = 1'b0;
        tick("storeWait");
        check("storeWait.dmemWEN", dmemWEN, 1'b1);
        enable = 1'b1; dhit = 1'b1; ex_memWrite = 1'b0; ex_memRead = 1'b1;
        ex_aluOut = 32'h84; ex_writeReg = 5'd9; ex_regWEN = 1'b1; ex_memToReg = 1'b1;
        tick("backToBack");
        check("backToBack.dmemWEN", dmemWEN, 1'b0);
        check("backToBack.dmemREN", dmemREN, 1'b1);
        check("backToBack.addr", dmemaddr, 32'h84);

        // Flush with the load still outstanding.
        clearInputs();
        flush = 1'b1;
        tick("flushReq");
        check("flushReq.dmemREN", dmemREN, 1'b0);
        check("flushReq.valid", mem_valid, 1'b0);
        check("flushReq.regWEN", mem_regWEN, 1'b0);
        check("flushReq.busy", mem_busy, 1'b0);

        // Bubble carrying a store, then a write to r0.
        clearInputs();
        enable = 1'b1; ex_valid = 1'b0; ex_memWrite = 1'b1; ex_regWEN = 1'b1; ex_writeReg = 5'd7;
        tick("bubble");
        check("bubble.dmemWEN", dmemWEN, 1'b0);
        check("bubble.regWEN", mem_regWEN, 1'b0);
        ex_valid = 1'b1; ex_memWrite = 1'b0; ex_writeReg = 5'd0;
        tick("regZero");
        check("regZero.regWEN", mem_regWEN, 1'b0);

        // Sticky halt.
        clearInputs();
        enable = 1'b1; ex_valid = 1'b1; ex_halt = 1'b1;
        tick("haltSet");
        ex_halt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ex_pc = $urandom; ex_writeReg = 5'($urandom_range(1, 31)); ex_regWEN = 1'b1;
            tick("haltHold");
            check("haltHold.halt", mem_halt, 1'b1);
        end
        clearInputs();
        flush = 1'b1;
        tick("haltFlush");
        check("haltFlush.halt", mem_halt, 1'b0);

        // Random traffic; never advances over an unfinished access.
        for (int i = 0; i < 3000; i++) begin
            randomizeEx();
            RST    = $urandom_range(0, 99) == 0;
            flush  = $urandom_range(0, 19) == 0;
            enable = $urandom_range(0, 2) != 0;
            dhit   = $urandom_range(0, 2) == 0;
            if (!RST && !flush && (model.readPending || model.writePending) && !dhit)
                enable = 1'b0;
            tick("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
